c3lib_ckg_en_ctrl: RTL
======================

Name: c3lib_ckg_en_ctrl

Overview:
- Control-side partner of the c3lib positive-edge clock gater; generates the gater's clk_en from consumer requests and activity.
- Runs on the free-running (ungated) clock; returns clk_ack only while the gated clock is guaranteed running.
- Idle timeout with drain window: clk_en drops only after clk_ack has been low for DRAIN_CYC cycles.
- One instance per gated clock domain, placed beside its clock gater.

Parameters:
- CNT_W, 8: width of the internal wake/idle/drain counters; every *_CYC must be at most 2^CNT_W-1.
- WAKE_CYC, 2: cycles from clk_en rising to clk_ack rising (covers gater latch plus distribution); minimum 1.
- IDLE_CYC, 16: consecutive inactive cycles in ON before drain starts; minimum 1.
- DRAIN_CYC, 2: cycles from clk_ack falling to clk_en falling; minimum 1.
- STAT_W, 16: width of the gated-cycle statistics counter (Optional Feature only).

Ports:
- clk  in  1  free-running source clock, same clock as the gater's clk input
- rst  in  1  synchronous reset, active-high
- clk_req  in  1  level request from the consumer for the gated clock
- busy  in  1  downstream activity indication; keeps the clock alive
- force_on  in  1  software/debug override; treated as permanent activity
- clk_en  out  1  registered enable to the gater's clk_en
- clk_ack  out  1  registered; gated clock running and stable
- ctrl_state  out  2  FSM state: OFF=0, WAKE=1, ON=2, DRAIN=3

Behaviour:
- Reset: one clk edge with rst=1 gives state OFF, clk_en=0, clk_ack=0, all counters 0. rst asserted in any state forces OFF at the next edge; clk_en may drop without draining.
- act = clk_req | busy | force_on, sampled at each rising edge. All outputs are registered and are a pure function of the state.
- OFF (clk_en=0, clk_ack=0):
  - act=1 moves to WAKE and loads cnt=WAKE_CYC-1.
- WAKE (clk_en=1, clk_ack=0):
  - Decrement cnt each cycle; when cnt==0, move to ON.
  - There is no abort: act falling during WAKE still proceeds to ON.
  - Latency: act sampled high at edge E gives clk_en=1 after E and clk_ack=1 after E+WAKE_CYC.
- ON (clk_en=1, clk_ack=1):
  - Idle counter reloads IDLE_CYC-1 on any cycle with act=1.
  - Otherwise it decrements; at 0 with act=0, move to DRAIN and load cnt=DRAIN_CYC-1.
  - Net timing: last act=1 sampled at edge N gives DRAIN after edge N+IDLE_CYC.
- DRAIN (clk_en=1, clk_ack=0):
  - act=1 returns directly to ON, because the clock never stopped. clk_ack re-rises the following edge and the idle counter reloads.
  - Otherwise decrement; at cnt==0 move to OFF.
  - Net timing: clk_en=0 after edge N+IDLE_CYC+DRAIN_CYC.
- clk_en never falls while clk_ack=1, except on reset.
- Simultaneous events:
  - act=1 on the same edge the idle counter would expire: stay in ON (act wins).
  - act=1 on the last DRAIN cycle: go to ON, not OFF.
- Counters never wrap: they load, decrement and stop at 0.

Optional Feature:
- Macro: C3LIB_CKG_EN_CTRL_STATS_EN.
- When defined, adds ports stat_clr (in, 1) and gated_cyc_cnt (out, STAT_W).
  - gated_cyc_cnt increments on every edge where registered clk_en==0.
  - It saturates at all-ones and does not wrap.
  - stat_clr=1 clears it to 0 next edge; clear has priority over increment.
  - rst clears it to 0.
- When not defined, both ports and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 3 cycles with clk_req=1 -> clk_en=0, clk_ack=0, ctrl_state=0 throughout; after release clk_en=1 at next edge, clk_ack=1 two edges later (WAKE_CYC=2).
- Idle shutdown (defaults): clk_req pulse 1 cycle at edge 10 -> clk_en=1 after edge 10, clk_ack=1 after edge 12, ctrl_state=3 and clk_ack=0 after edge 26, clk_en=0 after edge 28.
- busy keepalive: clk_req low, busy toggles high every 15 cycles for 200 cycles -> state stays ON, clk_ack held 1.
- DRAIN re-entry: clk_req rises on the first DRAIN cycle -> ctrl_state=2 and clk_ack=1 next edge; clk_en never falls.
- Boundary: WAKE_CYC=1, IDLE_CYC=1, DRAIN_CYC=1 -> clk_ack one edge after clk_en; single idle cycle enters DRAIN; clk_en falls one edge after clk_ack.
- Stats (macro defined, STAT_W=4): hold OFF 20 cycles -> gated_cyc_cnt saturates at 15; stat_clr=1 together with clk_en=0 -> reads 0 next edge.

Source files
------------

// File: rtl/c3lib_ckg_en_ctrl.sv
// Enable controller for the c3lib positive-edge clock gater: wake delay, idle timeout, drain window.
// Optional gated-cycle statistics counter when C3LIB_CKG_EN_CTRL_STATS_EN is defined.
module c3lib_ckg_en_ctrl #(
    parameter int CNT_W     = 8,
    parameter int WAKE_CYC  = 2,
    parameter int IDLE_CYC  = 16,
    parameter int DRAIN_CYC = 2,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_req,
    input  logic              busy,
    input  logic              force_on,
`ifdef C3LIB_CKG_EN_CTRL_STATS_EN
    input  logic              stat_clr,
    output logic [STAT_W-1:0] gated_cyc_cnt,
`endif
    output logic              clk_en,
    output logic              clk_ack,
    output logic [1:0]        ctrl_state
);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        WAKE  = 2'd1,
        ON    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAKE_LD  = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(IDLE_CYC - 1);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] idle_cnt, idle_nxt;
    logic             act;

    assign act        = clk_req | busy | force_on;
    assign ctrl_state = state;

    // The idle counter follows activity in every state, so the timeout is
    // measured from the last request even when that request woke the clock.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (act) begin
            idle_nxt = IDLE_LD;
        end else if (idle_cnt != '0) begin
            idle_nxt = idle_cnt - CNT_ONE;
        end else begin
            idle_nxt = '0;
        end

        case (state)
            OFF: begin
                if (act) begin
                    state_nxt = WAKE;
                    cnt_nxt   = WAKE_LD;
                end
            end
            WAKE: begin
                if (cnt == '0) begin
                    state_nxt = ON;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            ON: begin
                if (!act && idle_cnt == '0) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = DRAIN_LD;
                end
            end
            DRAIN: begin
                // Clock never stopped during drain, so activity returns straight to ON.
                if (act) begin
                    state_nxt = ON;
                end else if (cnt == '0) begin
                    state_nxt = OFF;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: state_nxt = OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OFF;
            cnt      <= '0;
            idle_cnt <= '0;
            clk_en   <= 1'b0;
            clk_ack  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            idle_cnt <= idle_nxt;
            clk_en   <= (state_nxt != OFF);
            clk_ack  <= (state_nxt == ON);
        end
    end

`ifdef C3LIB_CKG_EN_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            gated_cyc_cnt <= '0;
        end else if (!clk_en && gated_cyc_cnt != '1) begin
            gated_cyc_cnt <= gated_cyc_cnt + STAT_W'(1);
        end
    end
`endif

endmodule
